// File: rtl/subservient_reset_pkg.sv
// rtl/subservient_reset_pkg.sv - shared state type and sizing helper for the reset sequencer
package subservient_reset_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_INIT = 2'd1,
    CORE_DLY  = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  function automatic int clog2_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/subservient_btn_debounce.sv
// rtl/subservient_btn_debounce.sv - button synchronizer and level debouncer
module subservient_btn_debounce
  import subservient_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pressed
);

  localparam int CW = clog2_max(DEBOUNCE_CYCLES, 2, 2, 2) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_LEVEL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [CW-1:0] cnt;

  // sample is 1 when the synchronized button reads as pressed
  assign sample = sync2 ^ IDLE_LEVEL;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1     <= IDLE_LEVEL;
      sync2     <= IDLE_LEVEL;
      cnt       <= '0;
      o_pressed <= 1'b0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      if (sample == o_pressed) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        o_pressed <= sample;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/subservient_reset_seq.sv
// rtl/subservient_reset_seq.sv - staged memory/core reset release with init timeout
module subservient_reset_seq
  import subservient_reset_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CORE_DELAY      = 8,
  parameter int INIT_TIMEOUT    = 1048576,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_init_done,
  output logic o_rst_mem,
  output logic o_rst_core,
  output logic o_busy,
  output logic o_timeout
);

  localparam int CW = clog2_max(HOLD_CYCLES, CORE_DELAY, INIT_TIMEOUT, 2) + 1;
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST    = CW'(CORE_DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'((INIT_TIMEOUT == 0) ? 0 : INIT_TIMEOUT - 1);
  localparam bit            TIMEOUT_EN   = (INIT_TIMEOUT != 0);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          btn_pressed;

  subservient_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_btn    (i_btn),
    .o_pressed(btn_pressed)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // A held button keeps the sequencer parked in HOLD with the counter cleared
  always_ff @(posedge i_clk) begin
    if (i_rst || btn_pressed) begin
      state      <= HOLD;
      cnt        <= '0;
      o_rst_mem  <= 1'b1;
      o_rst_core <= 1'b1;
      o_busy     <= 1'b1;
      o_timeout  <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state     <= WAIT_INIT;
            cnt       <= '0;
            o_rst_mem <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_INIT: begin
          if (i_init_done) begin
            state <= CORE_DLY;
            cnt   <= '0;
          end else if (TIMEOUT_EN && cnt == TIMEOUT_LAST) begin
            // release the core anyway so a debugger can attach
            state     <= CORE_DLY;
            cnt       <= '0;
            o_timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        CORE_DLY: begin
          if (cnt == CORE_LAST) begin
            state      <= RUN;
            cnt        <= '0;
            o_rst_core <= 1'b0;
            o_busy     <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_reset_seq.sv
// tb/tb_subservient_reset_seq.sv - self-checking bench for subservient_reset_seq
module tb_subservient_reset_seq;

  localparam int HOLD = 16;
  localparam int DEB  = 4;
  localparam int CD   = 8;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic init_done = 1'b0;
  logic rst_mem, rst_core, busy, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  subservient_reset_seq #(
    .HOLD_CYCLES    (HOLD),
    .DEBOUNCE_CYCLES(DEB),
    .CORE_DELAY     (CD),
    .INIT_TIMEOUT   (TO),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn      (btn),
    .i_init_done(init_done),
    .o_rst_mem  (rst_mem),
    .o_rst_core (rst_core),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  // Reference model: time since the sequence (re)started and the time WAIT_INIT ended
  int  elapsed = 0;
  int  wait_end = -1;
  bit  m_to = 0;
  bit  acc = 0;
  bit  d1 = 0, d2 = 0;
  bit  hist[$];
  logic e_mem, e_core, e_busy, e_to;

  task automatic model_step();
    bit samp;
    bit all_diff;
    if (rst) begin
      elapsed = 0; wait_end = -1; m_to = 0; acc = 0; d1 = 0; d2 = 0;
      hist.delete();
    end else begin
      if (acc) begin
        elapsed = 0; wait_end = -1; m_to = 0;
      end else begin
        if (elapsed >= HOLD && wait_end < 0) begin
          if (init_done) wait_end = elapsed + 1;
          else if (elapsed - HOLD == TO - 1) begin
            wait_end = elapsed + 1;
            m_to = 1;
          end
        end
        if (elapsed < (1 << 20)) elapsed++;
      end
      samp = d2; d2 = d1; d1 = (btn == 1'b0);
      hist.push_back(samp);
      if (hist.size() > DEB) void'(hist.pop_front());
      all_diff = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == acc) all_diff = 0;
      if (all_diff) begin
        acc = !acc;
        hist.delete();
      end
    end
    e_mem  = (elapsed < HOLD);
    e_core = !(wait_end >= 0 && elapsed >= wait_end + CD);
    e_busy = e_core;
    e_to   = m_to;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("model_rst_mem", rst_mem, e_mem);
    chk("model_rst_core", rst_core, e_core);
    chk("model_busy", busy, e_busy);
    chk("model_timeout", timeout, e_to);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart(input logic init);
    rst = 1'b1; btn = 1'b1; init_done = init;
    ticks(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst;
    logic pressed;
    logic init;
    int   n;
    logic mem;
    logic core;
    logic bsy;
    logic to;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 5,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 15, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0};

    // Power-up sequence from the table
    for (int r = 0; r < 6; r++) begin
      rst = tbl[r].rst; btn = ~tbl[r].pressed; init_done = tbl[r].init;
      ticks(tbl[r].n);
      chk($sformatf("tbl%0d_rst_mem", r), rst_mem, tbl[r].mem);
      chk($sformatf("tbl%0d_rst_core", r), rst_core, tbl[r].core);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_timeout", r), timeout, tbl[r].to);
    end

    // Init handshake 50 cycles into WAIT_INIT
    restart(1'b0);
    ticks(HOLD);
    chk("hs_mem_released", rst_mem, 1'b0);
    ticks(50);
    init_done = 1'b1;
    ticks(1 + CD - 1);
    chk("hs_core_held", rst_core, 1'b1);
    tick();
    chk("hs_core_released", rst_core, 1'b0);
    chk("hs_no_timeout", timeout, 1'b0);

    // Init arriving on the last allowed WAIT_INIT cycle beats the timeout
    restart(1'b0);
    ticks(HOLD + TO - 1);
    init_done = 1'b1;
    ticks(1 + CD);
    chk("edge_core_released", rst_core, 1'b0);
    chk("edge_no_timeout", timeout, 1'b0);

    // Timeout
    restart(1'b0);
    ticks(HOLD + TO - 1);
    chk("to_not_yet", timeout, 1'b0);
    tick();
    chk("to_set", timeout, 1'b1);
    chk("to_core_held", rst_core, 1'b1);
    ticks(CD - 1);
    chk("to_core_still_held", rst_core, 1'b1);
    tick();
    chk("to_core_released", rst_core, 1'b0);
    ticks(10);
    chk("to_sticky_run", timeout, 1'b1);

    // Glitches shorter than the debounce window are ignored
    for (int len = 1; len <= 3; len++) begin
      btn = 1'b0;
      ticks(len);
      btn = 1'b1;
      ticks(12);
      chk($sformatf("glitch%0d_core", len), rst_core, 1'b0);
      chk($sformatf("glitch%0d_mem", len), rst_mem, 1'b0);
    end

    // Held press: resets assert on the 7th edge after the raw press
    btn = 1'b0;
    ticks(6);
    chk("press_mem_not_yet", rst_mem, 1'b0);
    tick();
    chk("press_mem_asserted", rst_mem, 1'b1);
    chk("press_core_asserted", rst_core, 1'b1);
    chk("press_timeout_cleared", timeout, 1'b0);
    ticks(3);
    btn = 1'b1;
    init_done = 1'b1;
    ticks(6 + HOLD + 1 + CD + 4);
    chk("rerun_core_released", rst_core, 1'b0);
    chk("rerun_timeout_clear", timeout, 1'b0);

    // i_rst during CORE_DLY
    restart(1'b1);
    ticks(HOLD + 4);
    chk("mid_in_core_dly", rst_core, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_mem", rst_mem, 1'b1);
    chk("mid_core", rst_core, 1'b1);
    rst = 1'b0;
    ticks(HOLD - 1);
    chk("mid_mem_hold", rst_mem, 1'b1);
    tick();
    chk("mid_mem_rel", rst_mem, 1'b0);
    ticks(CD + 2);

    // Press accepted on the CORE_DLY->RUN edge: core reset never drops
    restart(1'b1);
    ticks(HOLD + 2);
    btn = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("sim_core_held", rst_core, 1'b1);
    end
    chk("sim_mem", rst_mem, 1'b1);
    btn = 1'b1;
    ticks(40);

    // Randomized traffic against the model
    begin
      int pulse = 0;
      for (int i = 0; i < 3000; i++) begin
        if (pulse > 0) pulse--;
        else if ($urandom_range(0, 39) == 0) pulse = $urandom_range(1, 8);
        btn = (pulse > 0) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 29) == 0) init_done = ~init_done;
        rst = ($urandom_range(0, 499) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
